mt_prng_core: RTL and testbench
===============================

// Module: mt_prng_core
// PURPOSE
//  Full Mersenne-Twister PRNG core: seeds, twists and tempers in hardware. Generalised over word
//  width (MT19937 / MT19937-64) with a valid/ready output stream, runtime reseed and automatic
//  re-twist after every N words. Sits between the seed source and any consumer of random words.
// PARAMETERS
//  W 32 word width (32 or 64); all constants below are W bits wide
//  N 624 state words (312 for W=64)        M 397 middle offset (156 for W=64)
//  R 31 lower-mask bits                    A 32'h9908B0DF twist matrix coefficient
//  U,D 11, 32'hFFFFFFFF temper shift/mask  S,B 7, 32'h9D2C5680 temper shift/mask
//  T,C 15, 32'hEFC60000 temper shift/mask  L 18 final temper shift
//  F 1812433253 init multiplier            DEFAULT_SEED 5489 seed used after reset
// PORTS
//  clk        in  1  clock
//  rst        in  1  synchronous active-high reset
//  seed_valid in  1  reseed request (seed_ready is always 1, so not a port)
//  seed       in  W  seed value, sampled when seed_valid=1
//  rnd_valid  out 1  rnd_data holds a valid tempered word
//  rnd_ready  in  1  consumer accepts rnd_data this cycle
//  rnd_data   out W  tempered output word
//  busy       out 1  core is in INIT or TWIST
// BEHAVIOUR
//  - Reset values: rnd_valid=0, rnd_data=0, busy=1. State=INIT with seed DEFAULT_SEED, idx=0.
//  - INIT (N cycles): mt[0]=seed; mt[i]=F*(mt[i-1]^(mt[i-1]>>(W-2)))+i, mod 2^W; one write/cycle.
//  - TWIST (N+1 cycles): 1 prefetch cycle, then one word/cycle in place, i=0..N-1:
//    y=(mt[i]&UPPER)|(mt[i+1 mod N]&LOWER), UPPER=~((1<<R)-1), LOWER=(1<<R)-1;
//    mt[i]=mt[(i+M) mod N]^(y>>1)^(y[0]?A:0). Reads at i+M>=N and i=N-1 see already-twisted words.
//    mt[i+1] read this cycle is held as next cycle's mt[i]: 2 read ports, 1 write port.
//  - OUT: words mt[0..N-1] tempered in order: y^=(y>>U)&D; y^=(y<<S)&B; y^=(y<<T)&C; y^=y>>L.
//    Output is registered; 1 cycle load after TWIST, so first rnd_valid appears 2N+2 cycles after
//    the first cycle with rst=0.
//  - Handshake: a word transfers when rnd_valid&&rnd_ready. While rnd_valid&&!rnd_ready,
//    rnd_data and rnd_valid hold stable. Within a block, throughput is 1 word/cycle while
//    rnd_ready=1 (read-ahead prefetch, no bubbles).
//  - Block end: transfer of word N-1 -> rnd_valid=0 next cycle, state=TWIST (busy=1), then resume
//    with word 0 of the new block.
//  - Reseed: seed_valid=1 in any state aborts the current operation. The next cycle is INIT with
//    the new seed, idx=0, rnd_valid=0; any pending word is discarded. If a transfer occurs in the
//    same cycle, that word counts as consumed.
//  - seed_valid during INIT restarts INIT. rst has priority over seed_valid.
//  - All arithmetic is modulo 2^W. The index is $clog2(N) bits and wraps explicitly at N-1, never
//    by overflow.
// STRUCTURE
//  - Package mt_pkg: state enum {INIT, TWIST, LOAD, OUT}; localparam presets MT32_* and MT64_*
//    (N, M, R, A, U, D, S, B, T, C, L, F).
//  - Sub-module mt_temper: combinational, parametrised by W/U/D/S/B/T/C/L, output registered by
//    the parent.
//  - State RAM: N x W array with 2 async read ports and 1 write port. The core FSM, index
//    counters and twist datapath live in the parent.
// TESTING
//  1 W=32 defaults, release rst, rnd_ready=1 -> first words 3499211612, 581869302; 10000th word
//    4123659995 (crosses 16 re-twists).
//  2 W=64 MT64 preset, release rst -> first word 14514284786278117030.
//  3 Random rnd_ready backpressure, W=32 -> output stream identical to a C++ std::mt19937 golden
//    model; rnd_data stable whenever valid&&!ready.
//  4 Reseed 5489 mid-block after 100 words; also reseed mid-TWIST -> rnd_valid drops the next cycle,
//    and the sequence restarts at 3499211612 after 2N+2 cycles.
//  5 seed_valid in the same cycle as a transfer of word N-1 -> that word is counted, no TWIST,
//    INIT starts next cycle.
//  6 rst asserted mid-OUT -> rnd_valid=0 the next cycle; stream restarts from the DEFAULT_SEED
//    sequence.

Source files
------------

// File: rtl/mt_pkg.sv
// Shared definitions for the Mersenne-Twister core: FSM states and the
// standard MT19937 / MT19937-64 parameter presets.
package mt_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TWIST = 2'd1,
    LOAD  = 2'd2,
    OUT   = 2'd3
  } mt_state_e;

  localparam logic [31:0] MT_DEFAULT_SEED32 = 32'd5489;
  localparam logic [63:0] MT_DEFAULT_SEED64 = 64'd5489;

  // MT19937 (32-bit)
  localparam int          MT32_N = 624;
  localparam int          MT32_M = 397;
  localparam int          MT32_R = 31;
  localparam logic [31:0] MT32_A = 32'h9908B0DF;
  localparam int          MT32_U = 11;
  localparam logic [31:0] MT32_D = 32'hFFFFFFFF;
  localparam int          MT32_S = 7;
  localparam logic [31:0] MT32_B = 32'h9D2C5680;
  localparam int          MT32_T = 15;
  localparam logic [31:0] MT32_C = 32'hEFC60000;
  localparam int          MT32_L = 18;
  localparam logic [31:0] MT32_F = 32'd1812433253;

  // MT19937-64
  localparam int          MT64_N = 312;
  localparam int          MT64_M = 156;
  localparam int          MT64_R = 31;
  localparam logic [63:0] MT64_A = 64'hB5026F5AA96619E9;
  localparam int          MT64_U = 29;
  localparam logic [63:0] MT64_D = 64'h5555555555555555;
  localparam int          MT64_S = 17;
  localparam logic [63:0] MT64_B = 64'h71D67FFFEDA60000;
  localparam int          MT64_T = 37;
  localparam logic [63:0] MT64_C = 64'hFFF7EEE000000000;
  localparam int          MT64_L = 43;
  localparam logic [63:0] MT64_F = 64'd6364136223846793005;

endpackage

// File: rtl/mt_temper.sv
// Combinational Mersenne-Twister tempering; the parent registers the result.
module mt_temper #(
  parameter int           W = 32,
  parameter int           U = 11,
  parameter logic [W-1:0] D = 32'hFFFFFFFF,
  parameter int           S = 7,
  parameter logic [W-1:0] B = 32'h9D2C5680,
  parameter int           T = 15,
  parameter logic [W-1:0] C = 32'hEFC60000,
  parameter int           L = 18
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Four xor-shift-mask steps applied in sequence
  always_comb begin
    logic [W-1:0] t;
    t = x;
    t = t ^ ((t >> U) & D);
    t = t ^ ((t << S) & B);
    t = t ^ ((t << T) & C);
    t = t ^ (t >> L);
    y = t;
  end

endmodule

// File: rtl/mt_prng_core.sv
// Mersenne-Twister core: seeds the state RAM, twists it in place, then streams
// tempered words over a valid/ready interface, re-twisting after every N words.
module mt_prng_core
  import mt_pkg::*;
#(
  parameter int           W            = 32,
  parameter int           N            = MT32_N,
  parameter int           M            = MT32_M,
  parameter int           R            = MT32_R,
  parameter logic [W-1:0] A            = MT32_A,
  parameter int           U            = MT32_U,
  parameter logic [W-1:0] D            = MT32_D,
  parameter int           S            = MT32_S,
  parameter logic [W-1:0] B            = MT32_B,
  parameter int           T            = MT32_T,
  parameter logic [W-1:0] C            = MT32_C,
  parameter int           L            = MT32_L,
  parameter logic [W-1:0] F            = MT32_F,
  parameter logic [W-1:0] DEFAULT_SEED = MT_DEFAULT_SEED32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_valid,
  input  logic [W-1:0] seed,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic [W-1:0] rnd_data,
  output logic         busy
);

  localparam int           IW    = $clog2(N);
  localparam logic [W-1:0] LOWER = {{(W-R){1'b0}}, {R{1'b1}}};
  localparam logic [W-1:0] UPPER = ~LOWER;

  mt_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  seed_q, seed_d;
  logic [W-1:0]  cur_q, cur_d;      // previous INIT word / mt[i] during TWIST
  logic          pre_q, pre_d;      // TWIST prefetch cycle pending
  logic          rnd_valid_q, rnd_valid_d;
  logic [W-1:0]  rnd_data_q, rnd_data_d;

  logic [W-1:0]  mt_mem [N];
  logic          we;
  logic [IW-1:0] waddr;
  logic [W-1:0]  wdata;

  logic [IW-1:0] idx_inc, addr_a, addr_b;
  logic [IW:0]   sum_b;
  logic [W-1:0]  rd_a, rd_b, y_tw, tw_val, init_val, tmp_out;

  // Index arithmetic and the two asynchronous RAM read ports
  always_comb begin
    idx_inc = (idx_q == IW'(N-1)) ? '0 : idx_q + 1'b1;
    sum_b   = {1'b0, idx_q} + (IW+1)'(M);
    addr_b  = (sum_b >= (IW+1)'(N)) ? IW'(sum_b - (IW+1)'(N)) : IW'(sum_b);
    // Prefetch and LOAD read the current index; all other reads look one ahead
    addr_a  = (((state_q == TWIST) && pre_q) || (state_q == LOAD)) ? idx_q : idx_inc;
    rd_a    = mt_mem[addr_a];
    rd_b    = mt_mem[addr_b];
  end

  // Seed recurrence and twist datapath
  always_comb begin
    init_val = (idx_q == '0) ? seed_q
             : F * (cur_q ^ (cur_q >> (W-2))) + {{(W-IW){1'b0}}, idx_q};
    y_tw     = (cur_q & UPPER) | (rd_a & LOWER);
    tw_val   = rd_b ^ (y_tw >> 1) ^ (y_tw[0] ? A : '0);
  end

  mt_temper #(
    .W(W), .U(U), .D(D), .S(S), .B(B), .T(T), .C(C), .L(L)
  ) u_temper (
    .x(rd_a),
    .y(tmp_out)
  );

  // Core FSM: next state, index, RAM write and output register loads
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    seed_d      = seed_q;
    cur_d       = cur_q;
    pre_d       = pre_q;
    rnd_valid_d = rnd_valid_q;
    rnd_data_d  = rnd_data_q;
    we          = 1'b0;
    waddr       = idx_q;
    wdata       = init_val;
    unique case (state_q)
      INIT: begin
        we    = 1'b1;
        cur_d = init_val;
        if (idx_q == IW'(N-1)) begin
          idx_d   = '0;
          pre_d   = 1'b1;
          state_d = TWIST;
        end else begin
          idx_d = idx_inc;
        end
      end
      TWIST: begin
        cur_d = rd_a;
        if (pre_q) begin
          pre_d = 1'b0;
        end else begin
          we    = 1'b1;
          wdata = tw_val;
          if (idx_q == IW'(N-1)) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      LOAD: begin
        rnd_data_d  = tmp_out;
        rnd_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (rnd_valid_q && rnd_ready) begin
          if (idx_q == IW'(N-1)) begin
            rnd_valid_d = 1'b0;
            idx_d       = '0;
            pre_d       = 1'b1;
            state_d     = TWIST;
          end else begin
            rnd_data_d = tmp_out;
            idx_d      = idx_inc;
          end
        end
      end
      default: state_d = INIT;
    endcase
    // A reseed aborts whatever is in progress and discards any pending word
    if (seed_valid) begin
      state_d     = INIT;
      idx_d       = '0;
      pre_d       = 1'b0;
      seed_d      = seed;
      rnd_valid_d = 1'b0;
      we          = 1'b0;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      idx_q       <= '0;
      seed_q      <= DEFAULT_SEED;
      pre_q       <= 1'b0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      pre_q       <= pre_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  // Datapath holding register, no reset needed
  always_ff @(posedge clk) begin
    cur_q <= cur_d;
  end

  // State RAM write port
  always_ff @(posedge clk) begin
    if (we) mt_mem[waddr] <= wdata;
  end

  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign busy      = (state_q == INIT) || (state_q == TWIST);

endmodule

// File: tb/tb_mt_prng_core.sv
// Testbench for mt_prng_core: 32-bit and 64-bit instances checked against a
// software Mersenne-Twister reference model with random backpressure.
module tb_mt_prng_core;
  import mt_pkg::*;

  localparam int N32 = MT32_N;
  localparam int N64 = MT64_N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, seed_valid, rnd_ready, rnd_valid, busy;
  logic [31:0] seed, rnd_data;
  logic        rst64, seed_valid64, rnd_ready64, rnd_valid64, busy64;
  logic [63:0] seed64, rnd_data64;

  mt_prng_core #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data), .busy(busy)
  );

  mt_prng_core #(
    .W(64), .N(MT64_N), .M(MT64_M), .R(MT64_R), .A(MT64_A),
    .U(MT64_U), .D(MT64_D), .S(MT64_S), .B(MT64_B), .T(MT64_T), .C(MT64_C),
    .L(MT64_L), .F(MT64_F), .DEFAULT_SEED(MT_DEFAULT_SEED64)
  ) dut64 (
    .clk(clk), .rst(rst64), .seed_valid(seed_valid64), .seed(seed64),
    .rnd_valid(rnd_valid64), .rnd_ready(rnd_ready64), .rnd_data(rnd_data64), .busy(busy64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference models (textbook genrand form) ----------------
  bit [31:0] mt32 [N32];
  int        idx32;
  bit [63:0] mt64 [N64];
  int        idx64;

  function automatic void m32_seed(input bit [31:0] s);
    mt32[0] = s;
    for (int i = 1; i < N32; i++)
      mt32[i] = 32'd1812433253 * (mt32[i-1] ^ (mt32[i-1] >> 30)) + 32'(i);
    idx32 = N32;
  endfunction

  function automatic bit [31:0] m32_next();
    bit [31:0] y;
    if (idx32 >= N32) begin
      for (int i = 0; i < N32; i++) begin
        y = (mt32[i] & 32'h80000000) | (mt32[(i+1) % N32] & 32'h7FFFFFFF);
        mt32[i] = mt32[(i+397) % N32] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
      end
      idx32 = 0;
    end
    y = mt32[idx32];
    idx32++;
    y ^= y >> 11;
    y ^= (y << 7) & 32'h9D2C5680;
    y ^= (y << 15) & 32'hEFC60000;
    y ^= y >> 18;
    return y;
  endfunction

  function automatic int rem32();
    return (idx32 >= N32) ? N32 : N32 - idx32;
  endfunction

  function automatic void m64_seed(input bit [63:0] s);
    mt64[0] = s;
    for (int i = 1; i < N64; i++)
      mt64[i] = 64'd6364136223846793005 * (mt64[i-1] ^ (mt64[i-1] >> 62)) + 64'(i);
    idx64 = N64;
  endfunction

  function automatic bit [63:0] m64_next();
    bit [63:0] y;
    if (idx64 >= N64) begin
      for (int i = 0; i < N64; i++) begin
        y = (mt64[i] & 64'hFFFFFFFF80000000) | (mt64[(i+1) % N64] & 64'h7FFFFFFF);
        mt64[i] = mt64[(i+156) % N64] ^ (y >> 1) ^ (y[0] ? 64'hB5026F5AA96619E9 : 64'h0);
      end
      idx64 = 0;
    end
    y = mt64[idx64];
    idx64++;
    y ^= (y >> 29) & 64'h5555555555555555;
    y ^= (y << 17) & 64'h71D67FFFEDA60000;
    y ^= (y << 37) & 64'hFFF7EEE000000000;
    y ^= y >> 43;
    return y;
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [31:0] last_w;

  // Consume n words with rnd_ready asserted rdy_pct percent of the time
  task automatic consume32(input int n, input int rdy_pct);
    int       got;
    int       budget;
    logic     hold;
    logic [31:0] prev;
    got = 0; budget = 0; hold = 1'b0; prev = '0;
    while (got < n && budget < n * 4 + 2000) begin
      @(negedge clk);
      budget++;
      if (hold) begin
        chk("hold_valid", rnd_valid, 1);
        chk("hold_data", rnd_data, prev);
      end
      rnd_ready = ($urandom_range(99) < rdy_pct);
      if (rnd_valid && rnd_ready) begin
        last_w = rnd_data;
        chk("word", rnd_data, m32_next());
        got++;
      end
      hold = rnd_valid && !rnd_ready;
      prev = rnd_data;
    end
    if (got < n) chk("consume_timeout", got, n);
    @(negedge clk);
    rnd_ready = 1'b0;
  endtask

  // Called at the first negedge after a reset/reseed edge
  task automatic wait_first32();
    for (int k = 1; k <= 2 * N32 + 2; k++) begin
      @(negedge clk);
      if (k == 2 * N32 + 1) chk("valid_before_first", rnd_valid, 0);
      if (k == 2 * N32 + 2) chk("valid_at_first", rnd_valid, 1);
    end
  endtask

  task automatic reseed32(input logic [31:0] s);
    @(negedge clk);
    seed_valid = 1'b1;
    seed       = s;
    rnd_ready  = 1'b0;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("reseed_valid_drop", rnd_valid, 0);
    chk("reseed_busy", busy, 1);
    m32_seed(s);
  endtask

  initial begin
    rst = 1'b1; seed_valid = 1'b0; seed = '0; rnd_ready = 1'b0;
    rst64 = 1'b1; seed_valid64 = 1'b0; seed64 = '0; rnd_ready64 = 1'b0;
    last_w = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", rnd_valid, 0);
    chk("reset_data", rnd_data, 0);
    chk("reset_busy", busy, 1);
    rst = 1'b0;

    // Default-seed stream, known reference words
    wait_first32();
    m32_seed(32'd5489);
    chk("first_word_const", rnd_data, 32'd3499211612);
    chk("out_not_busy", busy, 0);
    consume32(1, 100);
    consume32(1, 100);
    chk("second_word_const", last_w, 32'd581869302);
    consume32(9998, 100);
    chk("word_10000_const", last_w, 32'd4123659995);

    // 64-bit preset
    chk("reset64_valid", rnd_valid64, 0);
    chk("reset64_busy", busy64, 1);
    rst64 = 1'b0;
    for (int k = 1; k <= 2 * N64 + 2; k++) begin
      @(negedge clk);
      if (k == 2 * N64 + 1) chk("valid64_before_first", rnd_valid64, 0);
    end
    chk("valid64_at_first", rnd_valid64, 1);
    m64_seed(64'd5489);
    chk("first64_const", rnd_data64, 64'd14514284786278117030);
    chk("first64_model", rnd_data64, m64_next());
    rnd_ready64 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("word64_valid", rnd_valid64, 1);
      chk("word64", rnd_data64, m64_next());
    end
    rnd_ready64 = 1'b0;

    // Random seed with random backpressure across several blocks
    reseed32($urandom);
    consume32(1500, 70);

    // Reseed mid-block
    reseed32(32'd5489);
    wait_first32();
    consume32(100, 80);
    reseed32(32'd5489);
    wait_first32();
    chk("restart_mid_block", rnd_data, 32'd3499211612);

    // Reseed mid-TWIST
    consume32(rem32(), 100);
    repeat (10) @(negedge clk);
    chk("twist_busy", busy, 1);
    chk("twist_valid", rnd_valid, 0);
    reseed32(32'd5489);
    wait_first32();
    chk("restart_mid_twist", rnd_data, 32'd3499211612);

    // Reseed in the same cycle as transfer of the block's last word
    consume32(rem32() - 1, 90);
    for (int k = 0; k < 10 && !rnd_valid; k++) @(negedge clk);
    seed_valid = 1'b1;
    seed       = 32'd5489;
    rnd_ready  = 1'b1;
    chk("last_word_with_seed", rnd_data, m32_next());
    @(negedge clk);
    seed_valid = 1'b0;
    rnd_ready  = 1'b0;
    chk("seed_xfer_valid", rnd_valid, 0);
    chk("seed_xfer_busy", busy, 1);
    m32_seed(32'd5489);
    wait_first32();
    chk("restart_after_xfer", rnd_data, 32'd3499211612);

    // Reset during output
    consume32(50, 100);
    @(negedge clk);
    rst = 1'b1;
    rnd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", rnd_valid, 0);
    chk("rst_mid_data", rnd_data, 0);
    chk("rst_mid_busy", busy, 1);
    m32_seed(32'd5489);
    wait_first32();
    consume32(3, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
